uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side deserializer for the icebreaker UART path. Sits directly behind the `rx_i` pin: it synchronizes the asynchronous line, detects and validates start bits with 16x oversampling, majority-votes each data bit and presents complete bytes on a ready/valid interface. Downstream logic, and ultimately the transmitter driving `tx_o`, consumes these bytes. Framing and overrun errors are flagged, never silently merged into data.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLK_FREQ_HZ`, 50_250_000: frequency of `clk_i` (PLL output).
- `BAUD_RATE`, 9600: line rate.
- `MSB_FIRST`, 0: 0 = bit 0 on the line first (standard UART); 1 = MSB first, for loopback against MSB-first benches.
- `clk_i` input 1: single clock, all logic on its rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `rx_i` input 1: asynchronous serial line, idle high.
- `data_o` output DATA_WIDTH: received byte; held stable while `valid_o`=1.
- `valid_o` output 1: byte available.
- `ready_i` input 1: consumer accepts; transfer on `valid_o && ready_i`.
- `frame_err_o` output 1: one-cycle pulse; stop bit sampled low.
- `overrun_o` output 1: one-cycle pulse; completed byte dropped because `valid_o` was still high.

## Operation
- `rx_i` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rx_s`.
- Oversample tick: divider `DIV = round(CLK_FREQ_HZ / (16*BAUD_RATE))`. The default gives 327. The counter width is `$clog2(DIV)`. It wraps at `DIV-1` and emits a one-cycle `tick`. The counter is cleared on start detection, so sampling is phase-aligned to the falling edge.
- Bit sampling: a 4-bit tick counter per bit. Samples are taken at ticks 7, 8 and 9, and the bit value is the 2-of-3 majority. The bit closes at tick 15.
- FSM states:
  - IDLE: wait for `rx_s` falling from 1 to 0, then go to START.
  - START: at the majority point, if the voted value is 1 (glitch), return to IDLE with no flags. Otherwise go to DATA with the bit index at 0 at the end of the bit.
  - DATA: shift the voted bit into the shift register, right-shift when `MSB_FIRST`=0, left otherwise. After `DATA_WIDTH` bits, go to STOP.
  - STOP: act at the majority point, without waiting for the end of the bit:
    - Voted 1 and `valid_o`=0: load `data_o`, set `valid_o`, go to IDLE.
    - Voted 1 and `valid_o`=1: pulse `overrun_o`. `data_o` and `valid_o` are unchanged; the new byte is discarded. Go to IDLE.
    - Voted 0: pulse `frame_err_o` and discard the byte. Go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This stops a held-low line from being seen as repeated start bits.
- Handshake: `valid_o` clears on the cycle after `valid_o && ready_i`. If a load and an accept happen in the same cycle, the load wins: `valid_o` stays 1 with the new data and no overrun is flagged.
- Reset values: `data_o`=0, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0, FSM in IDLE, synchronizer flops at 1. An asserted reset mid-frame aborts the frame with no flags. Reception resumes at the next falling edge after release.

## Timing
- Start edge on `rx_i` to FSM leaving IDLE: 2-3 cycles (synchronizer).
- `valid_o` rises 1 cycle after the stop-bit majority point. That is about (1 + DATA_WIDTH + 0.5) × 16 × DIV cycles after detection: 9.5 bit times, roughly 49,700 cycles at the defaults.
- `frame_err_o` and `overrun_o` pulse in the same cycle that `valid_o` would have risen.
- Earliest next start detection is in IDLE, immediately after the stop-bit majority point. This tolerates about ±4% baud mismatch.

## Structure
- `uart_pkg`:
  - state enum `uart_rx_state_e` (IDLE, START, DATA, STOP, BREAK).
  - `OVERSAMPLE`=16 and sample indices 7/8/9.
  - function `baud_div(clk_hz, baud)` returning the rounded divisor, so a future `uart_tx` shares the same divisor math.
- Sub-module `uart_baud_gen`: the divider with a synchronous `clear_i` and a `tick_o` output. Reused by the TX side at 1x.

## Test plan
- Send 0xA5 at 9600 baud with `ready_i`=1 → exactly one `valid_o` cycle with `data_o`=0xA5. Repeat with `MSB_FIRST`=1 and an MSB-first stimulus → 0xA5. No error pulses.
- Drive a low pulse of 1/4 bit on idle `rx_i` → FSM returns to IDLE, no `valid_o`, no error pulses. A following 0x3C is received correctly.
- Send 0x55 with the stop bit driven 0 → `frame_err_o` pulses once, `valid_o` stays 0. Hold the line low for 3 bit times, then send 0x81 → 0x81 is received; no spurious frames.
- Hold `ready_i`=0 and send 0x3C then 0xC3 → `data_o` stays 0x3C with `valid_o` high, and `overrun_o` pulses once at the second stop bit. Raise `ready_i` → `valid_o` drops the next cycle.
- Back-to-back 0x00 and 0xFF with no idle gap and `ready_i`=1 → two `valid_o` pulses carrying 0x00 then 0xFF.
- Assert `rst_ni`=0 during data bit 4 of 0xF0 → outputs at reset values, no pulses. Release and send 0x0F → 0x0F received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, oversampling constants and baud divisor math.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;
  function automatic int baud_div(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE));
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider emitting a one-cycle tick every DIV clocks.
module uart_baud_gen #(
  parameter int DIV = 327
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick_o = cnt == W'(DIV - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else cnt <= (clear_i || tick_o) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver with majority voting and ready/valid output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 50_250_000,
  parameter int BAUD_RATE   = 9600,
  parameter int MSB_FIRST   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);
  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  uart_rx_state_e state, state_n;
  logic [1:0] sync;
  logic rx_s, rx_prev, tick, fall, vote, mid, last, start, load, ovr, ferr, shift, s_a, s_b;
  logic [3:0] sub;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] shreg;
  assign rx_s  = sync[1];
  assign fall  = rx_prev & ~rx_s;
  assign vote  = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign mid   = tick && sub == 4'(SAMPLE_C);
  assign last  = tick && sub == 4'(OVERSAMPLE - 1);
  assign start = state == IDLE && fall;
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(start),
    .tick_o (tick)
  );
  always_comb begin
    state_n = state;
    load = 1'b0;
    ovr = 1'b0;
    ferr = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE:  state_n = fall ? START : IDLE;
      START: state_n = (mid && vote) ? IDLE : last ? DATA : START;
      DATA: begin
        shift = mid;
        state_n = (last && idx == IW'(DATA_WIDTH - 1)) ? STOP : DATA;
      end
      STOP: if (mid) begin
        state_n = vote ? IDLE : BREAK;
        load = vote && (!valid_o || ready_i);
        ovr = vote && valid_o && !ready_i;
        ferr = !vote;
      end
      BREAK:   state_n = rx_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync <= 2'b11;
      rx_prev <= 1'b1;
      sub <= '0;
      idx <= '0;
      s_a <= 1'b1;
      s_b <= 1'b1;
      shreg <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      sync <= {sync[0], rx_i};
      rx_prev <= rx_s;
      sub <= start ? '0 : tick ? sub + 1'b1 : sub;
      if (tick && sub == 4'(SAMPLE_A)) s_a <= rx_s;
      if (tick && sub == 4'(SAMPLE_B)) s_b <= rx_s;
      idx <= state != DATA ? '0 : last ? idx + 1'b1 : idx;
      if (shift) shreg <= MSB_FIRST != 0 ? {shreg[DATA_WIDTH-2:0], vote} : {vote, shreg[DATA_WIDTH-1:1]};
      if (load) data_o <= shreg;
      // a load in the same cycle as an accept keeps valid high with the new byte
      valid_o <= load || (valid_o && !ready_i);
      frame_err_o <= ferr;
      overrun_o <= ovr;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames checked against a frame-level receive model.
module tb_uart_rx;
  localparam int CLK_HZ = 6_400_000;
  localparam int BAUD = 100_000;
  localparam int BIT = 64;
  logic clk = 0, rst_n = 0, rx = 1, rx_m = 1, ready = 1, ready_m = 1;
  logic [7:0] data, data_m;
  logic valid, valid_m, ferr, ferr_m, ovr, ovr_m;
  int checks = 0, failures = 0, n_ferr = 0, n_ovr = 0, n_err_m = 0, n_vcyc = 0;
  logic [7:0] got[$], got_m[$], exp_q[$];
  always #5 clk = ~clk;
  uart_rx #(.DATA_WIDTH(8), .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MSB_FIRST(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_o(data), .valid_o(valid),
    .ready_i(ready), .frame_err_o(ferr), .overrun_o(ovr));
  uart_rx #(.DATA_WIDTH(8), .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MSB_FIRST(1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_m), .data_o(data_m), .valid_o(valid_m),
    .ready_i(ready_m), .frame_err_o(ferr_m), .overrun_o(ovr_m));
  always @(negedge clk) begin
    if (valid && ready) got.push_back(data);
    if (valid) n_vcyc++;
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    if (valid_m && ready_m) got_m.push_back(data_m);
    if (ferr_m || ovr_m) n_err_m++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] exp, input bit m);
    logic [7:0] v;
    v = 'x;
    if (m && got_m.size() > 0) v = got_m.pop_front();
    if (!m && got.size() > 0) v = got.pop_front();
    chk(tag, {24'h0, v}, {24'h0, exp});
  endtask
  task automatic put(input logic v, input bit m);
    if (m) rx_m = v;
    else rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [7:0] b, input logic stop, input bit m);
    put(1'b0, m);
    for (int i = 0; i < 8; i++) put(m ? b[7-i] : b[i], m);
    put(stop, m);
  endtask
  initial begin
    logic [7:0] b;
    logic stop;
    int v0, f0, o0, e_ferr;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'h0, data}, 0);
    chk("rst_valid", {31'h0, valid}, 0);
    chk("rst_pulses", {30'h0, ferr, ovr}, 0);
    rst_n = 1;
    put(1'b1, 0);
    v0 = n_vcyc;
    frame(8'hA5, 1'b1, 0);
    pop_chk("a5_lsb", 8'hA5, 0);
    chk("a5_valid_cycles", n_vcyc - v0, 1);
    chk("a5_extra", got.size(), 0);
    frame(8'hA5, 1'b1, 1);
    pop_chk("a5_msb", 8'hA5, 1);
    chk("msb_extra", got_m.size(), 0);
    chk("msb_errs", n_err_m, 0);
    chk("lsb_quiet", got.size(), 0);
    rx = 0;
    repeat (BIT / 4) @(posedge clk);
    #1;
    put(1'b1, 0);
    put(1'b1, 0);
    chk("glitch_valid", got.size(), 0);
    chk("glitch_pulses", n_ferr + n_ovr, 0);
    frame(8'h3C, 1'b1, 0);
    pop_chk("after_glitch", 8'h3C, 0);
    frame(8'h55, 1'b0, 0);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_no_byte", got.size(), 0);
    repeat (3) put(1'b0, 0);
    put(1'b1, 0);
    frame(8'h81, 1'b1, 0);
    pop_chk("after_break", 8'h81, 0);
    chk("break_no_spurious", got.size() + n_ferr, 1);
    ready = 0;
    frame(8'h3C, 1'b1, 0);
    frame(8'hC3, 1'b1, 0);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_data_held", {24'h0, data}, 32'h3C);
    chk("ovr_valid_held", {31'h0, valid}, 1);
    chk("ovr_no_ferr", n_ferr, 1);
    @(posedge clk);
    #2;
    ready = 1;
    @(negedge clk);
    chk("accept_valid_hi", {31'h0, valid}, 1);
    @(negedge clk);
    chk("accept_valid_lo", {31'h0, valid}, 0);
    pop_chk("ovr_kept", 8'h3C, 0);
    chk("ovr_dropped", got.size(), 0);
    frame(8'h00, 1'b1, 0);
    frame(8'hFF, 1'b1, 0);
    pop_chk("b2b_first", 8'h00, 0);
    pop_chk("b2b_second", 8'hFF, 0);
    f0 = n_ferr;
    o0 = n_ovr;
    put(1'b0, 0);
    repeat (4) put(1'b0, 0);
    rx = 1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    rst_n = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_data", {24'h0, data}, 0);
    chk("midrst_valid", {31'h0, valid}, 0);
    chk("midrst_pulses", {30'h0, ferr, ovr}, 0);
    rst_n = 1;
    put(1'b1, 0);
    put(1'b1, 0);
    chk("midrst_no_byte", got.size(), 0);
    chk("midrst_no_flags", (n_ferr - f0) + (n_ovr - o0), 0);
    frame(8'h0F, 1'b1, 0);
    pop_chk("after_reset", 8'h0F, 0);
    e_ferr = n_ferr;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      frame(b, stop, 0);
      if (stop) exp_q.push_back(b);
      else begin
        e_ferr++;
        put(1'b1, 0);
      end
      repeat ($urandom_range(0, BIT)) @(posedge clk);
      #1;
    end
    chk("rnd_count", got.size(), exp_q.size());
    chk("rnd_ferr", n_ferr, e_ferr);
    while (exp_q.size() > 0) pop_chk("rnd_byte", exp_q.pop_front(), 0);
    chk("rnd_ovr", n_ovr, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
